// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data RAM between the MEM stage and a debug port,
// sequences variable-latency IO accesses with a pipeline stall, and keeps debug from starving.
module dmem_arbiter #(
    parameter int          AW         = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_7F00,
    parameter int          IO_TIMEOUT = 15,
    parameter int          STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_d,
    output logic          mem_we,
    input  logic [31:0]   mem_spo,
    output logic [7:0]    io_addr,
    output logic [31:0]   io_dout,
    output logic          io_we,
    output logic          io_rd,
    input  logic [31:0]   io_din,
    input  logic          io_ready,
    output logic          io_err
);
    localparam logic [1:0] IDLE = 2'd0, IO_ACCESS = 2'd1, IO_DONE = 2'd2;
    localparam int TW = $clog2(IO_TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   io_q, io_d, dbg_rdata_q, dbg_rdata_d;
    logic          dbg_ack_q, io_err_q, io_err_d;
    logic          cpu_io, dbg_io, idle, in_io, forced, cpu_ram, dbg_grant, dbg_ram;

    assign cpu_io    = cpu_addr >= IO_BASE;
    assign dbg_io    = dbg_addr >= IO_BASE;
    assign idle      = state_q == IDLE;
    assign in_io     = state_q == IO_ACCESS;
    assign forced    = starve_q == SW'(STARVE_LIM);
    // Outputs are gated by rst so a reset asserted mid-transaction releases the pipeline at once
    assign cpu_ram   = !rst && idle && cpu_req && !cpu_io && !forced;
    assign dbg_grant = !rst && dbg_req && !dbg_ack_q && !cpu_ram;
    assign dbg_ram   = dbg_grant && !dbg_io;

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        io_d     = io_q;
        io_err_d = io_err_q;
        if (idle && cpu_req && cpu_io) begin
            state_d = IO_ACCESS;
        end else if (in_io) begin
            tmo_d = tmo_q + 1'b1;
            if (io_ready) begin
                io_d    = io_din;
                state_d = IO_DONE;
            end else if (tmo_q == TW'(IO_TIMEOUT - 1)) begin
                io_d     = '0;
                io_err_d = 1'b1;
                state_d  = IO_DONE;
            end
        end else if (state_q == IO_DONE) begin
            state_d = IDLE;
        end
        starve_d    = dbg_grant ? '0 : (dbg_req && !dbg_ack_q && cpu_ram) ? starve_q + 1'b1 : starve_q;
        dbg_rdata_d = dbg_grant ? (dbg_io ? '0 : mem_spo) : dbg_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            starve_q    <= '0;
            io_q        <= '0;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            io_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            starve_q    <= starve_d;
            io_q        <= io_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_ack_q   <= dbg_grant;
            io_err_q    <= io_err_d;
        end
    end

    assign cpu_stall = !rst && ((idle && cpu_req && (cpu_io || forced)) || in_io);
    assign cpu_rdata = cpu_ram ? mem_spo : (state_q == IO_DONE) ? io_q : '0;
    assign mem_a     = cpu_ram ? cpu_addr[AW+1:2] : dbg_ram ? dbg_addr[AW+1:2] : '0;
    assign mem_d     = cpu_ram ? cpu_wdata : dbg_ram ? dbg_wdata : '0;
    assign mem_we    = (cpu_ram && cpu_we) || (dbg_ram && dbg_we);
    assign io_addr   = cpu_addr[7:0];
    assign io_dout   = in_io ? cpu_wdata : '0;
    assign io_we     = in_io && cpu_we;
    assign io_rd     = in_io && !cpu_we;
    assign io_err    = io_err_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
endmodule
